mpp20_beacon_rx: RTL and testbench
==================================

Name: mpp20_beacon_rx

Overview:
- Receive side of the MPP20 beacon link: consumes the 24-bit word stream produced by the beacon generator and recovers frames.
- Hunts for a sync header, collects the payload words, checks the XOR checksum, and reports each frame as good or bad.
- Sits between the beacon data bus and the downstream telemetry logger.
- Single clock domain, same Clk as the beacon generator.

Parameters:
- SYNC_PATTERN, 16'hEB90: required value of header bits [23:8].
- MAX_LEN, 32: maximum payload words per frame; legal range 1..255.
- TIMEOUT_CYC, 64: idle cycles allowed between words inside a frame; must be >= 2.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst_n  input  1  reset, asynchronous assert, active low.
- enable  input  1  receiver enable; low aborts and holds the block in HUNT.
- BeaconData_in  input  24  beacon word.
- BeaconValid_in  input  1  BeaconData_in is valid this cycle; no backpressure.
- Payload_out  output  24  recovered payload word.
- PayloadValid_out  output  1  one-cycle strobe qualifying Payload_out.
- PayloadIdx_out  output  8  index of Payload_out within the frame, 0-based.
- FrameStart_out  output  1  pulse when a valid header is accepted.
- FrameOk_out  output  1  pulse when the checksum matches.
- FrameErr_out  output  1  pulse on any frame error.
- ErrCode_out  output  2  error code: 0 LEN, 1 CSUM, 2 TIMEOUT, 3 ABORT; held until the next error.
- Busy_out  output  1  high in PAYLOAD and CHECK.

Behaviour:
- Reset value of every output is 0. State resets to HUNT; the length, index, XOR accumulator and gap counter reset to 0.
- All outputs are registered. Latency is 1 cycle from the input word to any strobe.
- Header word format: [23:8] is the sync field, [7:0] is L, the payload length.
- HUNT, on a valid word with [23:8]==SYNC_PATTERN:
  - If 1<=L<=MAX_LEN: latch L, clear the XOR accumulator and index, pulse FrameStart_out, go to PAYLOAD.
  - If L==0 or L>MAX_LEN: pulse FrameErr_out with ErrCode 0, stay in HUNT.
- HUNT, on any other word: discard silently.
- PAYLOAD, on each valid word:
  - Register it to Payload_out, pulse PayloadValid_out, and drive PayloadIdx_out with the current index.
  - XOR the word into the accumulator and increment the index.
  - After word index L-1, go to CHECK.
- Inside PAYLOAD, a word matching the sync field is ordinary data; the block does not resync.
- CHECK, on a valid word:
  - If it equals the accumulator: pulse FrameOk_out.
  - Otherwise: pulse FrameErr_out with ErrCode 1.
  - Either way, return to HUNT.
- Timeout:
  - In PAYLOAD and CHECK, the gap counter increments on each cycle without a valid word and clears on each valid word.
  - When the counter reaches TIMEOUT_CYC: FrameErr_out with ErrCode 2, return to HUNT.
  - A valid word arriving in the same cycle as the timeout wins; no timeout is raised.
- enable low:
  - If in PAYLOAD or CHECK: pulse FrameErr_out once with ErrCode 3, then go to HUNT.
  - If in HUNT: no pulse.
  - The input is ignored while enable is low.
- Payload words are delivered before the checksum is known. Downstream discards the frame on FrameErr_out.
- FrameOk_out and FrameErr_out are never high in the same cycle.
- Back-to-back frames are supported: a header may arrive in the cycle right after the checksum word.
- Rst_n asserted mid-frame: immediate return to the reset state, no error pulse.

Optional Feature:
- Macro: MPP20_BEACON_RX_STATS_EN.
- Defined: adds outputs FrameOkCnt_out[15:0] and FrameErrCnt_out[15:0].
  - They count FrameOk_out and FrameErr_out pulses.
  - They saturate at 16'hFFFF and reset to 0 on Rst_n.
- Undefined: the ports and counters are absent and the remaining behaviour is unchanged.

Decomposition:
- Shared package mpp20_beacon_pkg holds:
  - the state encoding (HUNT, PAYLOAD, CHECK);
  - the ErrCode constants;
  - the default SYNC_PATTERN;
  - the header field bit positions.
- The generator side also uses this package.
- One sub-module: mpp20_beacon_gapcnt, the timeout counter with clear and expiry outputs.

Test Plan:
- Header 24'hEB9003, then 24'h000001, 24'h000002, 24'h000004, then checksum 24'h000007 -> FrameStart; 3 payload strobes with idx 0,1,2; FrameOk pulse.
- Same frame with checksum 24'h000006 -> FrameErr, ErrCode 1, no FrameOk.
- Header with L=0, and header with L=33 at MAX_LEN=32 -> FrameErr, ErrCode 0, state stays HUNT.
- Header L=2, one payload word, then 64 idle cycles -> FrameErr, ErrCode 2 exactly at cycle 64. A variant with a word at cycle 64 gives no timeout.
- enable dropped mid-payload -> a single FrameErr with ErrCode 3, Busy_out low next cycle.
- Two frames back-to-back, with a payload word equal to 24'hEB9005 -> both frames good, no resync. With MPP20_BEACON_RX_STATS_EN defined, FrameOkCnt_out=2.

Source files
------------

// File: rtl/mpp20_beacon_pkg.sv
// Shared definitions for the MPP20 beacon link (generator and receiver):
// FSM state encoding, error codes, default sync word and header field positions.
package mpp20_beacon_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_e;

    localparam logic [1:0] ERR_LEN     = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

    localparam logic [15:0] DEFAULT_SYNC = 16'hEB90;

    localparam int HDR_SYNC_HI = 23;
    localparam int HDR_SYNC_LO = 8;
    localparam int HDR_LEN_HI  = 7;
    localparam int HDR_LEN_LO  = 0;

    function automatic logic len_legal(input logic [7:0] len, input logic [7:0] max_len);
        return (len != 8'd0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/mpp20_beacon_gapcnt.sv
// Inter-word gap counter: counts idle cycles while running, clears on a word,
// and flags expiry on the idle cycle that brings the count to TIMEOUT_CYC.
module mpp20_beacon_gapcnt #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || clear) begin
            cnt <= '0;
        end else if (cnt != CW'(TIMEOUT_CYC)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // A word in the expiring cycle takes precedence over the timeout.
    assign expired = run && !clear && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mpp20_beacon_rx.sv
// MPP20 beacon receiver: hunts for a sync header, forwards payload words and
// checks the XOR checksum. Define MPP20_BEACON_RX_STATS_EN for good/bad frame counters.
module mpp20_beacon_rx
    import mpp20_beacon_pkg::*;
#(
    parameter logic [15:0] SYNC_PATTERN = DEFAULT_SYNC,
    parameter int          MAX_LEN      = 32,
    parameter int          TIMEOUT_CYC  = 64
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        enable,
    input  logic [23:0] BeaconData_in,
    input  logic        BeaconValid_in,
    output logic [23:0] Payload_out,
    output logic        PayloadValid_out,
    output logic [7:0]  PayloadIdx_out,
    output logic        FrameStart_out,
    output logic        FrameOk_out,
    output logic        FrameErr_out,
    output logic [1:0]  ErrCode_out,
    output logic        Busy_out,
    output state_e      state_dbg
`ifdef MPP20_BEACON_RX_STATS_EN
    ,
    output logic [15:0] FrameOkCnt_out,
    output logic [15:0] FrameErrCnt_out
`endif
);

    state_e      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  idx_q, idx_d;
    logic [23:0] acc_q, acc_d;
    logic [23:0] payload_d;
    logic [7:0]  pidx_d;
    logic [1:0]  code_d;
    logic        pvalid_d, start_d, ok_d, err_d, busy_d;
    logic        gap_run, expired;
    logic [15:0] hdr_sync;
    logic [7:0]  hdr_len;

    assign hdr_sync  = BeaconData_in[HDR_SYNC_HI:HDR_SYNC_LO];
    assign hdr_len   = BeaconData_in[HDR_LEN_HI:HDR_LEN_LO];
    assign gap_run   = (state_q != HUNT) && enable;
    assign state_dbg = state_q;

    mpp20_beacon_gapcnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_gapcnt (
        .clk    (Clk),
        .rst_n  (Rst_n),
        .run    (gap_run),
        .clear  (BeaconValid_in),
        .expired(expired)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q          <= HUNT;
            len_q            <= '0;
            idx_q            <= '0;
            acc_q            <= '0;
            Payload_out      <= '0;
            PayloadValid_out <= 1'b0;
            PayloadIdx_out   <= '0;
            FrameStart_out   <= 1'b0;
            FrameOk_out      <= 1'b0;
            FrameErr_out     <= 1'b0;
            ErrCode_out      <= '0;
            Busy_out         <= 1'b0;
        end else begin
            state_q          <= state_d;
            len_q            <= len_d;
            idx_q            <= idx_d;
            acc_q            <= acc_d;
            Payload_out      <= payload_d;
            PayloadValid_out <= pvalid_d;
            PayloadIdx_out   <= pidx_d;
            FrameStart_out   <= start_d;
            FrameOk_out      <= ok_d;
            FrameErr_out     <= err_d;
            ErrCode_out      <= code_d;
            Busy_out         <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        payload_d = Payload_out;
        pidx_d    = PayloadIdx_out;
        code_d    = ErrCode_out;
        pvalid_d  = 1'b0;
        start_d   = 1'b0;
        ok_d      = 1'b0;
        err_d     = 1'b0;

        if (!enable) begin
            // Abort is reported only when a frame was actually in progress.
            if (state_q != HUNT) begin
                err_d  = 1'b1;
                code_d = ERR_ABORT;
            end
            state_d = HUNT;
        end else begin
            case (state_q)
                HUNT: begin
                    if (BeaconValid_in && hdr_sync == SYNC_PATTERN) begin
                        if (len_legal(hdr_len, 8'(MAX_LEN))) begin
                            len_d   = hdr_len;
                            idx_d   = '0;
                            acc_d   = '0;
                            start_d = 1'b1;
                            state_d = PAYLOAD;
                        end else begin
                            err_d  = 1'b1;
                            code_d = ERR_LEN;
                        end
                    end
                end
                PAYLOAD: begin
                    if (BeaconValid_in) begin
                        payload_d = BeaconData_in;
                        pvalid_d  = 1'b1;
                        pidx_d    = idx_q;
                        acc_d     = acc_q ^ BeaconData_in;
                        idx_d     = idx_q + 8'd1;
                        if (idx_q == len_q - 8'd1) begin
                            state_d = CHECK;
                        end
                    end else if (expired) begin
                        err_d   = 1'b1;
                        code_d  = ERR_TIMEOUT;
                        state_d = HUNT;
                    end
                end
                CHECK: begin
                    if (BeaconValid_in) begin
                        if (BeaconData_in == acc_q) begin
                            ok_d = 1'b1;
                        end else begin
                            err_d  = 1'b1;
                            code_d = ERR_CSUM;
                        end
                        state_d = HUNT;
                    end else if (expired) begin
                        err_d   = 1'b1;
                        code_d  = ERR_TIMEOUT;
                        state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        busy_d = (state_d != HUNT);
    end

`ifdef MPP20_BEACON_RX_STATS_EN
    // Counters advance in the same cycle their pulse appears and stick at all-ones.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            FrameOkCnt_out  <= '0;
            FrameErrCnt_out <= '0;
        end else begin
            if (ok_d && FrameOkCnt_out != 16'hFFFF) begin
                FrameOkCnt_out <= FrameOkCnt_out + 16'd1;
            end
            if (err_d && FrameErrCnt_out != 16'hFFFF) begin
                FrameErrCnt_out <= FrameErrCnt_out + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mpp20_beacon_rx.sv
// Self-checking bench for mpp20_beacon_rx: frame stimulus with a scoreboard of
// expected payload words and frame events compared on the falling clock edge.
module tb_mpp20_beacon_rx;
    import mpp20_beacon_pkg::*;

    localparam logic [31:0] EV_START = 32'h4;
    localparam logic [31:0] EV_OK    = 32'h2;

    logic        Clk;
    logic        Rst_n;
    logic        enable;
    logic [23:0] BeaconData_in;
    logic        BeaconValid_in;
    logic [23:0] Payload_out;
    logic        PayloadValid_out;
    logic [7:0]  PayloadIdx_out;
    logic        FrameStart_out;
    logic        FrameOk_out;
    logic        FrameErr_out;
    logic [1:0]  ErrCode_out;
    logic        Busy_out;
    state_e      state_dbg;
`ifdef MPP20_BEACON_RX_STATS_EN
    logic [15:0] FrameOkCnt_out;
    logic [15:0] FrameErrCnt_out;
`endif

    mpp20_beacon_rx dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .enable          (enable),
        .BeaconData_in   (BeaconData_in),
        .BeaconValid_in  (BeaconValid_in),
        .Payload_out     (Payload_out),
        .PayloadValid_out(PayloadValid_out),
        .PayloadIdx_out  (PayloadIdx_out),
        .FrameStart_out  (FrameStart_out),
        .FrameOk_out     (FrameOk_out),
        .FrameErr_out    (FrameErr_out),
        .ErrCode_out     (ErrCode_out),
        .Busy_out        (Busy_out),
        .state_dbg       (state_dbg)
`ifdef MPP20_BEACON_RX_STATS_EN
        ,
        .FrameOkCnt_out  (FrameOkCnt_out),
        .FrameErrCnt_out (FrameErrCnt_out)
`endif
    );

    // Clock and reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Scoreboard state
    logic [31:0] exp_pay_q[$];
    logic [31:0] exp_evt_q[$];
    logic [1:0]  exp_code;
    logic [23:0] pl[0:31];
    int          n_checks;
    int          n_fail;
    int          n_ok_exp;
    int          n_err_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ev_err(input logic [1:0] code);
        return {26'b0, code, 4'b0001};
    endfunction

    task automatic push_evt(input logic [31:0] e);
        exp_evt_q.push_back(e);
        if (e == EV_OK) n_ok_exp++;
        if (e[0]) n_err_exp++;
    endtask

    // Driver: present one input cycle; returns after the resulting outputs were sampled.
    task automatic drive(input logic v, input logic [23:0] d);
        BeaconValid_in = v;
        BeaconData_in  = d;
        @(posedge Clk);
        @(negedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 24'($urandom));
    endtask

    // Sends a header, len payload words from pl[], and a checksum word; flip corrupts it.
    task automatic send_frame(input logic [7:0] len, input logic [23:0] flip);
        logic [23:0] acc;
        acc = '0;
        push_evt(EV_START);
        drive(1'b1, {DEFAULT_SYNC, len});
        for (int i = 0; i < int'(len); i++) begin
            exp_pay_q.push_back({i[7:0], pl[i]});
            acc = acc ^ pl[i];
            drive(1'b1, pl[i]);
        end
        if (flip == 24'd0) push_evt(EV_OK);
        else push_evt(ev_err(ERR_CSUM));
        drive(1'b1, acc ^ flip);
    endtask

    function automatic logic [31:0] pop_pay();
        if (exp_pay_q.size() != 0) return exp_pay_q.pop_front();
        return '1;
    endfunction

    function automatic logic [31:0] pop_evt();
        if (exp_evt_q.size() != 0) return exp_evt_q.pop_front();
        return '1;
    endfunction

    // Monitor: compares every DUT output strobe against the scoreboard.
    always @(negedge Clk) begin
        logic [31:0] e;
        if (!Rst_n) begin
            exp_code = 2'd0;
        end else begin
            if (PayloadValid_out) begin
                e = pop_pay();
                check("payload", {PayloadIdx_out, Payload_out}, e);
            end
            if (FrameStart_out || FrameOk_out || FrameErr_out) begin
                e = pop_evt();
                check("frame_evt",
                      {26'b0, (FrameErr_out ? ErrCode_out : 2'b00), 1'b0,
                       FrameStart_out, FrameOk_out, FrameErr_out}, e);
                if (e != '1 && e[0]) exp_code = e[5:4];
            end
            check("err_code_hold", 32'(ErrCode_out), 32'(exp_code));
        end
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        n_ok_exp       = 0;
        n_err_exp      = 0;
        exp_code       = 2'd0;
        Rst_n          = 1'b0;
        enable         = 1'b1;
        BeaconValid_in = 1'b0;
        BeaconData_in  = '0;
        repeat (3) @(negedge Clk);
        #1;

        check("rst_payload", 32'(Payload_out), 32'h0);
        check("rst_idx", 32'(PayloadIdx_out), 32'h0);
        check("rst_strobes", {25'b0, PayloadValid_out, FrameStart_out, FrameOk_out,
                              FrameErr_out, ErrCode_out, Busy_out}, 32'h0);
        check("rst_state", 32'(state_dbg), 32'(HUNT));
        Rst_n = 1'b1;
        idle(2);

        // Non-sync word in HUNT is dropped silently.
        drive(1'b1, 24'h123456);
        check("hunt_discard_busy", 32'(Busy_out), 32'h0);

        // Good frame, then the same frame with a bad checksum.
        pl[0] = 24'h000001; pl[1] = 24'h000002; pl[2] = 24'h000004;
        send_frame(8'd3, 24'd0);
        idle(1);
        send_frame(8'd3, 24'h000001);
        idle(1);
        check("csum_err_state", 32'(state_dbg), 32'(HUNT));

        // Illegal lengths.
        push_evt(ev_err(ERR_LEN));
        drive(1'b1, {DEFAULT_SYNC, 8'd0});
        check("len0_state", 32'(state_dbg), 32'(HUNT));
        push_evt(ev_err(ERR_LEN));
        drive(1'b1, {DEFAULT_SYNC, 8'd33});
        check("len33_state", 32'(state_dbg), 32'(HUNT));
        check("len33_busy", 32'(Busy_out), 32'h0);

        // Timeout after exactly 64 idle cycles.
        push_evt(EV_START);
        drive(1'b1, {DEFAULT_SYNC, 8'd2});
        exp_pay_q.push_back({8'd0, 24'hABCDEF});
        drive(1'b1, 24'hABCDEF);
        idle(63);
        check("tmo_busy_63", 32'(Busy_out), 32'h1);
        push_evt(ev_err(ERR_TIMEOUT));
        idle(1);
        check("tmo_evt_seen", 32'(exp_evt_q.size()), 32'h0);
        check("tmo_state", 32'(state_dbg), 32'(HUNT));

        // A word arriving on the 64th gap cycle wins over the timeout.
        push_evt(EV_START);
        drive(1'b1, {DEFAULT_SYNC, 8'd2});
        exp_pay_q.push_back({8'd0, 24'h00F00F});
        drive(1'b1, 24'h00F00F);
        idle(63);
        exp_pay_q.push_back({8'd1, 24'h0000F0});
        drive(1'b1, 24'h0000F0);
        check("late_word_busy", 32'(Busy_out), 32'h1);
        push_evt(EV_OK);
        drive(1'b1, 24'h00F0FF);
        idle(3);

        // Abort: enable dropped mid-payload gives one error, then input is ignored.
        push_evt(EV_START);
        drive(1'b1, {DEFAULT_SYNC, 8'd3});
        exp_pay_q.push_back({8'd0, 24'h111111});
        drive(1'b1, 24'h111111);
        enable = 1'b0;
        push_evt(ev_err(ERR_ABORT));
        drive(1'b1, 24'h222222);
        check("abort_busy", 32'(Busy_out), 32'h0);
        check("abort_state", 32'(state_dbg), 32'(HUNT));
        drive(1'b1, {DEFAULT_SYNC, 8'd1});
        idle(1);
        enable = 1'b1;
        idle(1);

        // Back-to-back frames; a sync-looking payload word is just data.
        pl[0] = 24'hEB9005; pl[1] = 24'h000001;
        send_frame(8'd2, 24'd0);
        pl[0] = 24'h123456;
        send_frame(8'd1, 24'd0);
        idle(2);

        // Random frames including the length boundaries 1 and MAX_LEN.
        for (int f = 0; f < 4; f++) begin
            int len;
            len = (f == 0) ? 1 : (f == 1) ? 32 : int'($urandom_range(2, 31));
            for (int i = 0; i < len; i++) pl[i] = 24'($urandom);
            send_frame(8'(len), (f == 3) ? 24'(32'h1 << $urandom_range(0, 23)) : 24'd0);
            idle(int'($urandom_range(0, 3)));
        end

        // Reset mid-frame: immediate return to reset state, no error pulse.
        push_evt(EV_START);
        drive(1'b1, {DEFAULT_SYNC, 8'd3});
        exp_pay_q.push_back({8'd0, 24'h0A0B0C});
        drive(1'b1, 24'h0A0B0C);
        Rst_n = 1'b0;
        #2;
        check("midrst_state", 32'(state_dbg), 32'(HUNT));
        check("midrst_busy", 32'(Busy_out), 32'h0);
        check("midrst_payload", 32'(Payload_out), 32'h0);
`ifdef MPP20_BEACON_RX_STATS_EN
        check("midrst_okcnt", 32'(FrameOkCnt_out), 32'h0);
        n_ok_exp  = 0;
        n_err_exp = 0;
`endif
        @(negedge Clk);
        #1;
        Rst_n = 1'b1;
        idle(2);
        pl[0] = 24'h00000F; pl[1] = 24'h0000F0;
        send_frame(8'd2, 24'd0);
        idle(2);

`ifdef MPP20_BEACON_RX_STATS_EN
        check("stats_ok_cnt", 32'(FrameOkCnt_out), 32'(n_ok_exp));
        check("stats_err_cnt", 32'(FrameErrCnt_out), 32'(n_err_exp));
`endif
        check("pay_q_drained", 32'(exp_pay_q.size()), 32'h0);
        check("evt_q_drained", 32'(exp_evt_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
